fetch_stage: RTL

- Instruction-fetch stage directly upstream of pc_control.
- Holds the architectural PC register, drives instruction memory, and captures the returned instruction into the IF/ID pipeline register.
- Supplies `pc_cur` to pc_control's `PC_in` and loads pc_control's `PC_out` as `pc_next`.
- Handles memory wait, decode stall, branch flush and halt.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/if_id_reg.sv | 53 +++++
 rtl/fetch_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch state encoding
package cpu_pkg;

    localparam logic [3:0]  HLT_OPCODE = 4'hF;
    localparam logic [15:0] NOP_INSTR  = 16'h0000;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    function automatic logic is_halt_instr(input logic [15:0] instr);
        return instr[15:12] == HLT_OPCODE;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, clear and hold controls
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          clear_i,
    input  logic          hold_i,
    input  logic [DW-1:0] instr_i,
    input  logic [DW-1:0] pc_i,
    output logic [DW-1:0] instr_o,
    output logic [DW-1:0] pc_o,
    output logic          valid_o
);

    logic [DW-1:0] instr_q, instr_d;
    logic [DW-1:0] pc_q, pc_d;
    logic          valid_q, valid_d;

    // Clear beats hold so a redirect can kill a stalled instruction.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (!hold_i && load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage; FETCH_PERF_EN adds fetch/wait counters
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] pc_next,
    output logic [DW-1:0] pc_cur,
    output logic          imem_req,
    output logic [DW-1:0] imem_addr,
    input  logic [DW-1:0] imem_rdata,
    input  logic          imem_ready,
    input  logic          stall,
    input  logic          flush,
    output logic [DW-1:0] if_id_instr,
    output logic [DW-1:0] if_id_pc,
    output logic          if_id_valid,
    output logic          halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]   perf_fetch_cnt,
    output logic [15:0]   perf_wait_cnt
`endif
);

    fetch_state_e  state_q, state_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] redirect_q, redirect_d;
    logic          pending_q, pending_d;
    logic          halted_q, halted_d;
    logic          req_en_q;
    logic          ifid_load;
    logic          ifid_clear;
    logic          is_hlt;

    assign is_hlt = is_halt_instr(imem_rdata);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = redirect_q;
        pending_d  = pending_q;
        halted_d   = halted_q;
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        case (state_q)
            RUN: begin
                // The first cycle after reset only raises the request.
                if (req_en_q) begin
                    if (flush) begin
                        pc_d       = pc_next;
                        ifid_clear = 1'b1;
                    end else if (imem_ready) begin
                        if (!stall) begin
                            ifid_load = 1'b1;
                            if (is_hlt) begin
                                state_d  = HALT;
                                halted_d = 1'b1;
                            end else begin
                                pc_d = pc_next;
                            end
                        end
                    end else begin
                        state_d    = WAIT;
                        ifid_clear = !stall;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    ifid_clear = 1'b1;
                    if (imem_ready) begin
                        pc_d      = pc_next;
                        pending_d = 1'b0;
                        state_d   = RUN;
                    end else begin
                        redirect_d = pc_next;
                        pending_d  = 1'b1;
                    end
                end else if (imem_ready) begin
                    state_d = RUN;
                    if (pending_q) begin
                        pc_d       = redirect_q;
                        pending_d  = 1'b0;
                        ifid_clear = 1'b1;
                    end else if (!stall) begin
                        ifid_load = 1'b1;
                        if (is_hlt) begin
                            state_d  = HALT;
                            halted_d = 1'b1;
                        end else begin
                            pc_d = pc_next;
                        end
                    end
                end else begin
                    ifid_clear = !stall;
                end
            end
            HALT: begin
                if (flush) begin
                    pc_d       = pc_next;
                    halted_d   = 1'b0;
                    ifid_clear = 1'b1;
                    state_d    = RUN;
                end else begin
                    ifid_clear = !stall;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            redirect_q <= '0;
            pending_q  <= 1'b0;
            halted_q   <= 1'b0;
            req_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            pending_q  <= pending_d;
            halted_q   <= halted_d;
            req_en_q   <= 1'b1;
        end
    end

    if_id_reg #(.DW(DW)) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ifid_load),
        .clear_i (ifid_clear),
        .hold_i  (stall),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .instr_o (if_id_instr),
        .pc_o    (if_id_pc),
        .valid_o (if_id_valid)
    );

    assign pc_cur    = pc_q;
    assign imem_addr = pc_q;
    assign imem_req  = req_en_q && (state_q != HALT);
    assign halted    = halted_q;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (ifid_load && !ifid_clear && !stall && fetch_cnt_q != 16'hFFFF) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
        if (state_q == WAIT && wait_cnt_q != 16'hFFFF) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_wait_cnt  = wait_cnt_q;
`endif

endmodule
